fft_2d_out_collector: RTL and testbench
=======================================

Name: fft_2d_out_collector

Overview:
- Sink-side partner of the 2D FFT/IFFT array.
- Watches the array's frame-start pulse (`next_out`) and captures the following WIDTH result beats into a two-slot ping-pong buffer.
- Presents each complete WIDTH×WIDTH complex matrix to the downstream conv/pointwise-multiply stage over a valid/ready handshake.
- Turns the free-running, non-stallable FFT stream into a back-pressurable frame interface.

Parameters:
- WIDTH, 4: FFT size per dimension; legal values 4 and 8.
- DATA_WIDTH, 16: signed width of each real and imaginary component.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- next_out  in  1  single-cycle frame-start pulse from the FFT array
- in_data  in  WIDTH*2*DATA_WIDTH  one beat = WIDTH complex lanes; lane i at bits [i*2*DW +: 2*DW], {re,im}
- out_valid  out  1  complete frame available
- out_ready  in  1  downstream accepts frame
- out_data  out  WIDTH*WIDTH*2*DATA_WIDTH  matrix; element (beat b, lane i) at index b*WIDTH+i
- drop_cnt  out  16  frames lost for lack of a free slot; saturates at 16'hFFFF
- err_restart  out  1  sticky: `next_out` seen mid-capture
- busy  out  1  capture in progress

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, drop_cnt=0, err_restart=0, busy=0.
  - Both slots empty; write and read pointers = slot 0; FSM = IDLE.
- Frame timing:
  - The first data beat arrives in the cycle after `next_out`.
  - Beats 0..WIDTH-1 are on consecutive cycles; there are no gaps and no stall path upstream.
- FSM states:
  - IDLE:
    - `next_out` with a free slot -> CAPTURE, beat_cnt=0, busy=1.
    - `next_out` with no free slot -> DROP, drop_cnt+1.
  - CAPTURE:
    - Write in_data to slot[wr_ptr] row beat_cnt; beat_cnt+1.
    - After beat WIDTH-1: mark slot full, toggle wr_ptr, return to IDLE, busy=0.
  - DROP:
    - Count WIDTH beats and discard them, then return to IDLE.
    - `next_out` inside DROP is treated as in CAPTURE (restart rule).
- Restart rule:
  - `next_out` during CAPTURE/DROP sets err_restart.
  - The current partial frame is discarded (slot not marked full).
  - Capture restarts at beat 0 in the same target slot, or DROP is re-evaluated against slot availability.
- Back-to-back frames: `next_out` in the same cycle as the final beat is legal, with no error. The new frame targets the other slot.
- Output handshake:
  - out_valid=1 while slot[rd_ptr] is full; out_data is driven from slot[rd_ptr].
  - out_valid && out_ready frees the slot and toggles rd_ptr.
  - out_data must remain stable while out_valid && !out_ready.
- Simultaneous events:
  - A completed capture and an accepted output in the same cycle both take effect.
  - A slot freed this cycle counts as free for a `next_out` in the same cycle.
- Latency: out_valid rises one cycle after the final beat is written, i.e. WIDTH+1 cycles after the `next_out` cycle.
- Reset mid-frame: everything returns to reset values, and a partial frame is never presented.

Optional Feature:
- FFT_COLLECT_SCALE_EN:
  - When defined, each captured component is normalised for the inverse transform before storage.
  - Normalisation is an arithmetic right shift by S = 2*log2(WIDTH): 4 for WIDTH=4, 6 for WIDTH=8.
  - Round-half-up: add 2^(S-1), then shift.
  - Saturate at +2^(DATA_WIDTH-1)-1 if the rounding addition overflows.
  - The combinational path adds no latency.
- When undefined, data is stored unmodified.

Decomposition:
- Package fft_collect_pkg:
  - complex_t struct {logic signed re, im}.
  - FSM state enum {IDLE, CAPTURE, DROP}.
  - Functions clog2 and scale-shift constant S.
- Sub-module fft_round_shift:
  - Per-component rounding/saturating shifter.
  - Instantiated per lane only under FFT_COLLECT_SCALE_EN.

Test Plan:
- Single frame, WIDTH=4, out_ready=1:
  - Stimulus: `next_out` at cycle 10, beats 0..3 with lane i = {re=b*4+i, im=-(b*4+i)}.
  - Response: out_valid at cycle 15, matrix element k = {k,-k}, one-cycle valid.
- Back-pressure:
  - Stimulus: out_ready=0; three frames sent back-to-back.
  - Response: frames 1-2 buffered, frame 3 dropped, drop_cnt=1.
  - Release out_ready: frames 1 then 2 appear in order, and out_data is stable while stalled.
- Restart:
  - Stimulus: `next_out`, 2 beats, then `next_out` again plus 4 beats of 0x7.
  - Response: err_restart=1; exactly one frame presented, all elements 0x7.
- Simultaneous complete/accept:
  - Stimulus: continuous frames with `next_out` coincident with the final beat, out_ready=1.
  - Response: every frame delivered, drop_cnt=0, err_restart=0.
- Reset mid-capture:
  - Stimulus: reset asserted at beat 2.
  - Response: next cycle out_valid=0, busy=0, counters 0; no partial frame appears afterwards.
- FFT_COLLECT_SCALE_EN, WIDTH=4:
  - Stimulus: inputs 24, 23, -24, 32767.
  - Response: stored 2, 1, -1, 2048; verifies half-up rounding and correct arithmetic shift.

Source files
------------

// File: rtl/fft_collect_pkg.sv
// Shared types and helpers for the 2D FFT output collector.
package fft_collect_pkg;

    localparam int CPX_DW = 16;

    typedef struct packed {
        logic signed [CPX_DW-1:0] re;
        logic signed [CPX_DW-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DROP
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Inverse-transform normalisation for a WIDTH x WIDTH 2D FFT is 1/WIDTH^2.
    function automatic int scale_shift(input int width);
        return 2 * clog2(width);
    endfunction

endpackage

// File: rtl/fft_round_shift.sv
// Round-half-up arithmetic right shift of one signed component, saturating at +max.
module fft_round_shift #(
    parameter int DW = 16,
    parameter int S  = 4
) (
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] dout
);

    localparam logic signed [DW:0] HALF = (DW+1)'(2 ** (S - 1));
    localparam logic signed [DW:0] MAXV = (DW+1)'(2 ** (DW - 1) - 1);

    logic signed [DW:0] sum;
    logic signed [DW:0] shifted;

    // One guard bit keeps the rounding add exact before the shift.
    assign sum     = {din[DW-1], din} + HALF;
    assign shifted = sum >>> S;
    assign dout    = (shifted > MAXV) ? MAXV[DW-1:0] : shifted[DW-1:0];

endmodule

// File: rtl/fft_2d_out_collector.sv
// Captures FFT result frames into a ping-pong buffer and presents them over valid/ready.
// Optional input normalisation enabled by defining FFT_COLLECT_SCALE_EN.
module fft_2d_out_collector
    import fft_collect_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                next_out,
    input  logic [WIDTH*2*DATA_WIDTH-1:0]       in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [WIDTH*WIDTH*2*DATA_WIDTH-1:0] out_data,
    output logic [15:0]                         drop_cnt,
    output logic                                err_restart,
    output logic                                busy
);

    localparam int BEAT_W = WIDTH * 2 * DATA_WIDTH;
    localparam int CW     = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state, state_n;
    logic [CW-1:0]     beat_cnt, beat_n;
    logic              wr_ptr, wr_n, rd_ptr;
    logic [1:0]        full, full_eff, set_mask, clr_mask;
    logic              drop_inc, err_set, accept, last;
    logic [BEAT_W-1:0] beat_data;
    logic [BEAT_W-1:0] slot_mem [2][WIDTH];

`ifdef FFT_COLLECT_SCALE_EN
    for (genvar c = 0; c < 2 * WIDTH; c++) begin : g_scale
        fft_round_shift #(
            .DW (DATA_WIDTH),
            .S  (scale_shift(WIDTH))
        ) u_round_shift (
            .din  (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .dout (beat_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end
`else
    assign beat_data = in_data;
`endif

    assign out_valid = full[rd_ptr];
    assign accept    = out_valid & out_ready;
    assign clr_mask  = accept ? (2'b01 << rd_ptr) : 2'b00;
    // A slot released by this cycle's handshake is already usable by a new frame.
    assign full_eff  = full & ~clr_mask;
    assign last      = (beat_cnt == LAST);
    assign busy      = (state == CAPTURE);

    always_comb begin
        state_n  = state;
        beat_n   = beat_cnt;
        wr_n     = wr_ptr;
        set_mask = 2'b00;
        drop_inc = 1'b0;
        err_set  = 1'b0;
        if (state != IDLE) beat_n = beat_cnt + 1'b1;
        if (state == CAPTURE && last) begin
            set_mask = 2'b01 << wr_ptr;
            wr_n     = ~wr_ptr;
            state_n  = IDLE;
        end
        if (state == DROP && last) state_n = IDLE;
        // Frame start: a pulse on the final beat is a clean back-to-back start.
        if (next_out) begin
            if (state != IDLE && !last) err_set = 1'b1;
            beat_n = '0;
            if (!full_eff[wr_n]) begin
                state_n = CAPTURE;
            end else begin
                state_n  = DROP;
                drop_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            full        <= 2'b00;
            drop_cnt    <= '0;
            err_restart <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            wr_ptr   <= wr_n;
            full     <= full_eff | set_mask;
            if (accept) rd_ptr <= ~rd_ptr;
            if (drop_inc && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (err_set) err_restart <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE) slot_mem[wr_ptr][beat_cnt] <= beat_data;
    end

    always_comb begin
        out_data = '0;
        if (full[rd_ptr]) begin
            for (int b = 0; b < WIDTH; b++) begin
                out_data[b*BEAT_W +: BEAT_W] = slot_mem[rd_ptr][b];
            end
        end
    end

endmodule

// File: tb/tb_fft_2d_out_collector.sv
// Self-checking bench for fft_2d_out_collector against a queue-based frame model.
module tb_fft_2d_out_collector;

    localparam int W  = 4;
    localparam int DW = 16;
    localparam int BW = W * 2 * DW;
    localparam int FW = W * BW;
    localparam int S  = 4;
`ifdef FFT_COLLECT_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, next_out, out_ready, out_valid, err_restart, busy;
    logic [BW-1:0] in_data;
    logic [FW-1:0] out_data;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    fft_2d_out_collector #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_out    (next_out),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .drop_cnt    (drop_cnt),
        .err_restart (err_restart),
        .busy        (busy)
    );

    int passes = 0;
    int total  = 0;

    // Reference model: completed frames waiting downstream, plus the frame in flight.
    logic [FW-1:0] q[$];
    logic [FW-1:0] cur;
    int            cnt;
    bit            capturing, dropping, m_err;
    int            drops;

    function automatic logic [BW-1:0] scale_beat(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = d;
        if (SCALE) begin
            for (int c = 0; c < 2 * W; c++) begin
                int v;
                v = int'($signed(d[c*DW +: DW]));
                v = (v + (1 << (S - 1))) >>> S;
                if (v > 32767) v = 32767;
                r[c*DW +: DW] = v[DW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rbeat();
        logic [BW-1:0] r;
        for (int c = 0; c < BW / 32; c++) r[c*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        q.delete();
        cnt       = 0;
        capturing = 0;
        dropping  = 0;
        m_err     = 0;
        drops     = 0;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit nx, input logic [BW-1:0] d, input bit rdy, input bit rst);
        reset     = rst;
        next_out  = nx;
        in_data   = d;
        out_ready = rdy;
        #1;
        check("out_valid", FW'(out_valid), FW'(q.size() > 0));
        check("out_data", out_data, (q.size() > 0) ? q[0] : '0);
        check("drop_cnt", FW'(drop_cnt), FW'(drops));
        check("err_restart", FW'(err_restart), FW'(m_err));
        check("busy", FW'(busy), FW'(capturing));
        if (rst) begin
            model_clear();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (capturing || dropping) begin
                if (capturing) cur[cnt*BW +: BW] = scale_beat(d);
                cnt++;
                if (cnt == W) begin
                    if (capturing) q.push_back(cur);
                    capturing = 0;
                    dropping  = 0;
                end
            end
            if (nx) begin
                if (capturing || dropping) m_err = 1;
                cnt       = 0;
                capturing = 0;
                dropping  = 0;
                if (q.size() < 2) begin
                    capturing = 1;
                end else begin
                    dropping = 1;
                    if (drops < 65535) drops++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, rbeat(), rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b1, 1'b1);
    endtask

    // n frames, each next_out coinciding with the previous frame's final beat.
    task automatic send_frames(input int n, input bit rdy);
        step(1'b1, rbeat(), rdy, 1'b0);
        for (int f = 0; f < n; f++)
            for (int b = 0; b < W; b++)
                step((b == W - 1) && (f < n - 1), rbeat(), rdy, 1'b0);
    endtask

    initial begin
        logic [BW-1:0] beat;
        logic [BW-1:0] sevens;
        logic [FW-1:0] exp_frame;

        reset = 1'b1; next_out = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Single frame with element k = {k, -k}
        do_reset();
        idle(8, 1'b1);
        step(1'b1, rbeat(), 1'b1, 1'b0);
        for (int b = 0; b < W; b++) begin
            for (int i = 0; i < W; i++) begin
                int k;
                k = b * W + i;
                beat[i*2*DW +: 2*DW] = {16'(k), 16'(-k)};
            end
            exp_frame[b*BW +: BW] = scale_beat(beat);
            step(1'b0, beat, 1'b1, 1'b0);
        end
        check("single_valid", FW'(out_valid), FW'(1));
        check("single_data", out_data, exp_frame);
        idle(4, 1'b1);

        // Back-pressure: two buffered, third dropped
        do_reset();
        send_frames(3, 1'b0);
        idle(3, 1'b0);
        check("bp_drop", FW'(drop_cnt), FW'(1));
        idle(12, 1'b1);

        // Restart after two beats, then four beats of 0x7
        do_reset();
        for (int c = 0; c < 2 * W; c++) sevens[c*DW +: DW] = 16'h0007;
        step(1'b1, rbeat(), 1'b0, 1'b0);
        step(1'b0, rbeat(), 1'b0, 1'b0);
        step(1'b0, rbeat(), 1'b0, 1'b0);
        step(1'b1, rbeat(), 1'b0, 1'b0);
        repeat (W) step(1'b0, sevens, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int b = 0; b < W; b++) exp_frame[b*BW +: BW] = scale_beat(sevens);
        check("restart_err", FW'(err_restart), FW'(1));
        check("restart_valid", FW'(out_valid), FW'(1));
        check("restart_data", out_data, exp_frame);
        idle(4, 1'b1);

        // Continuous back-to-back frames with downstream always ready
        do_reset();
        send_frames(6, 1'b1);
        idle(4, 1'b1);
        check("b2b_drop", FW'(drop_cnt), FW'(0));
        check("b2b_err", FW'(err_restart), FW'(0));

        // Reset in the middle of a capture
        do_reset();
        step(1'b1, rbeat(), 1'b1, 1'b0);
        step(1'b0, rbeat(), 1'b1, 1'b0);
        step(1'b0, rbeat(), 1'b1, 1'b0);
        step(1'b0, rbeat(), 1'b1, 1'b1);
        check("rst_valid", FW'(out_valid), FW'(0));
        check("rst_busy", FW'(busy), FW'(0));
        idle(8, 1'b1);

        // Random traffic: mostly-ready then mostly-stalled downstream
        do_reset();
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 5) == 0, rbeat(), $urandom_range(0, 3) != 0, 1'b0);
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 5) == 0, rbeat(), $urandom_range(0, 3) == 0, 1'b0);
        idle(10, 1'b1);

`ifdef FFT_COLLECT_SCALE_EN
        // Rounding corners: 24 -> 2, 23 -> 1, -24 -> -1, 32767 -> 2048
        do_reset();
        step(1'b1, rbeat(), 1'b0, 1'b0);
        beat = '0;
        beat[0 +: 2*DW]    = {16'sd24, 16'sd23};
        beat[2*DW +: 2*DW] = {-16'sd24, 16'sd32767};
        step(1'b0, beat, 1'b0, 1'b0);
        repeat (W - 1) step(1'b0, '0, 1'b0, 1'b0);
        check("scale_24", FW'(out_data[DW +: DW]), FW'(16'd2));
        check("scale_23", FW'(out_data[0 +: DW]), FW'(16'd1));
        check("scale_m24", FW'(out_data[3*DW +: DW]), FW'(16'hFFFF));
        check("scale_max", FW'(out_data[2*DW +: DW]), FW'(16'd2048));
        idle(3, 1'b1);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
